// File: rtl/rv32m_muldiv_unit_if.sv
// Request/response bundle between the register-file read/write ports and the
// RV32M multiply/divide unit.
interface rv32m_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic            regwrite;
    logic [4:0]      rd_out;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, rs1_data, rs2_data, rd_in,
        input  busy, done, regwrite, rd_out, result
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd_in,
        output busy, done, regwrite, rd_out, result
    );
endinterface

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitudes are latched at start, 32
// shift-add or restoring-divide iterations run in CALC, signs are fixed in FIX.
module rv32m_muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic               clk,
    input logic               rst,
    rv32m_muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic              neg_q, neg_d;
    logic              sa_q, sa_d;
    logic [XLEN-1:0]   res_q, res_d;

    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cneg_wide(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    // Operand conditioning for the start cycle
    logic            signed_a, signed_b, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b;

    assign signed_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign signed_b = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b110);
    assign neg_a    = signed_a & bus.rs1_data[XLEN-1];
    assign neg_b    = signed_b & bus.rs2_data[XLEN-1];
    assign mag_a    = cneg(bus.rs1_data, neg_a);
    assign mag_b    = cneg(bus.rs2_data, neg_b);
    assign div_zero = bus.funct3[2] && (bus.rs2_data == '0);
    assign div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                      (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_data == '1);

    // One iteration of each algorithm
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod_fix;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_sh   = {rem_q, acc_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};
    // A set top bit means the shifted remainder already exceeds any divisor
    assign div_ge   = div_sh[XLEN] | ~div_diff[XLEN];
    assign prod_fix = cneg_wide(acc_q, neg_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        rd_out_d = rd_out_q;
        op_d     = op_q;
        rd_d     = rd_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        res_d    = res_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d  = bus.funct3;
                    rd_d  = bus.rd_in;
                    sa_d  = neg_a;
                    neg_d = neg_a ^ neg_b;
                    cnt_d = '0;
                    rem_d = '0;
                    if (bus.funct3[2]) begin
                        opnd_d = mag_b;
                        acc_d  = {{XLEN{1'b0}}, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {{XLEN{1'b0}}, mag_b};
                    end
                    if (div_zero) begin
                        res_d   = bus.funct3[1] ? bus.rs1_data : '1;
                        state_d = S_DONE;
                    end else if (div_ovf) begin
                        res_d   = bus.funct3[1] ? '0 : bus.rs1_data;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (!op_q[2]) begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end else begin
                    rem_d = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};
                end
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!op_q[2]) begin
                    res_d = (op_q == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                end else if (op_q[1]) begin
                    res_d = cneg(rem_q, sa_q);
                end else begin
                    res_d = cneg(acc_q[XLEN-1:0], neg_q);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d   = 1'b1;
                result_d = res_q;
                rd_out_d = rd_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and visible outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    // Datapath working registers
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        rd_q   <= rd_d;
        opnd_q <= opnd_d;
        acc_q  <= acc_d;
        rem_q  <= rem_d;
        neg_q  <= neg_d;
        sa_q   <= sa_d;
        res_q  <= res_d;
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.regwrite = done_q;
    assign bus.rd_out   = rd_out_q;
    assign bus.result   = result_q;
endmodule
